// File: rtl/led_frame_writer.sv
// MiniLED driver-RAM frame writer: double-buffered zone grey levels
// loaded over a stream, replayed each frame as a driver-RAM write burst.
module led_frame_writer #(
  parameter int NUM_LEDS     = 360,
  parameter int ADDR_W       = 10,
  parameter int GRAY_W       = 8,
  parameter int DATA_W       = 16,
  parameter int INIT_CYCLES  = 2500,
  parameter int FRAME_CYCLES = 420000,
  parameter int FLAG_CYCLES  = 30,
  parameter int WR_START     = 5,
  parameter int PATTERN_PER  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode_selector,
  input  logic [7:0]        gain,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [GRAY_W-1:0] in_data,
  input  logic              in_last,
  output logic              sdbpflag_wire,
  output logic              wt_en,
  output logic [ADDR_W-1:0] wtaddr_wire,
  output logic [DATA_W-1:0] wtdina_wire,
  output logic              frame_start,
  output logic              frame_err
);

  localparam int FCW = $clog2(FRAME_CYCLES);
  localparam int ICW = $clog2(INIT_CYCLES);
  localparam int AW  = $clog2(NUM_LEDS);
  localparam int PW  = $clog2(PATTERN_PER);
  localparam int SH  = DATA_W - GRAY_W - 8;

  localparam logic [FCW-1:0] F_ONE  = FCW'(1);
  localparam logic [FCW-1:0] F_LAST = FCW'(FRAME_CYCLES - 1);
  localparam logic [FCW-1:0] F_FLAG = FCW'(FLAG_CYCLES);
  localparam logic [FCW-1:0] F_WS   = FCW'(WR_START);
  localparam logic [FCW-1:0] F_WE   = FCW'(WR_START + NUM_LEDS - 1);
  localparam logic [ICW-1:0] I_LAST = ICW'(INIT_CYCLES - 1);
  localparam logic [AW-1:0]  A_LAST = AW'(NUM_LEDS - 1);
  localparam logic [PW-1:0]  P_LAST = PW'(PATTERN_PER - 1);
  localparam logic [PW-1:0]  P_HALF = PW'(PATTERN_PER / 2);
  localparam logic [PW-1:0]  P_T1   = PW'(PATTERN_PER / 3);
  localparam logic [PW-1:0]  P_T2   = PW'(2 * PATTERN_PER / 3);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t state_q, state_d;

  logic [ICW-1:0]    icnt_q, icnt_d;
  logic [FCW-1:0]    fcnt_q, fcnt_d;
  logic [PW-1:0]     pat_q, pat_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              bank_full_q, bank_full_d;
  logic              in_ready_q, in_ready_d;
  logic              sel_q, sel_d;
  logic              shown_q, shown_d;
  logic [1:0]        mode_q, mode_d;
  logic [7:0]        gain_q, gain_d;
  logic              flag_q, flag_d;
  logic              wt_en_q, wt_en_d;
  logic [ADDR_W-1:0] wtaddr_q, wtaddr_d;
  logic [DATA_W-1:0] wtdina_q, wtdina_d;
  logic              fstart_q, fstart_d;
  logic              ferr_q, ferr_d;

  logic [GRAY_W-1:0] mem0_q [NUM_LEDS];
  logic [GRAY_W-1:0] mem1_q [NUM_LEDS];
  logic              we0, we1;

  logic              run_d;
  logic              in_burst;
  logic              at_f0;
  logic              accept;
  logic [AW-1:0]     rd_idx;
  logic [GRAY_W-1:0] front_px;
  logic [GRAY_W+7:0] prod;
  logic [DATA_W-1:0] dval;

  always_comb begin
    state_d = state_q;
    icnt_d  = icnt_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      S_INIT: begin
        if (icnt_q == I_LAST) begin
          state_d = S_RUN;
          fcnt_d  = '0;
        end else begin
          icnt_d = icnt_q + ICW'(1);
        end
      end
      S_RUN: begin
        fcnt_d = (fcnt_q == F_LAST) ? '0 : fcnt_q + F_ONE;
      end
    endcase
  end

  // Outputs are registered from the next count so they line up with fcnt_q.
  always_comb begin
    run_d    = (state_d == S_RUN);
    in_burst = run_d && (fcnt_d >= F_WS) && (fcnt_d <= F_WE);
    rd_idx   = in_burst ? AW'(fcnt_d - F_WS) : '0;
    front_px = '0;
    if (shown_q) begin
      front_px = sel_q ? mem1_q[rd_idx] : mem0_q[rd_idx];
    end
    prod = {8'b0, front_px} * {{GRAY_W{1'b0}}, gain_q};
    dval = DATA_W'(prod) << SH;

    pat_d = pat_q;
    if (in_burst) begin
      pat_d = ((fcnt_d == F_WS) || (pat_q == P_LAST)) ? '0 : pat_q + PW'(1);
    end

    flag_d   = run_d && (fcnt_d >= F_ONE) && (fcnt_d <= F_FLAG);
    fstart_d = run_d && (fcnt_d == '0);
    wt_en_d  = in_burst;
    wtaddr_d = in_burst ? ADDR_W'(fcnt_d - F_WS) : '0;
    wtdina_d = '0;
    if (in_burst) begin
      unique case (mode_q)
        2'b00: wtdina_d = {gain_q, {(DATA_W-8){1'b0}}};
        2'b01: wtdina_d = (pat_d < P_HALF) ? '1 : dval;
        2'b10: begin
          if (pat_d < P_T1) wtdina_d = '1;
          else if (pat_d < P_T2) wtdina_d = DATA_W'(1) << (DATA_W - 8);
          else wtdina_d = '0;
        end
        2'b11: wtdina_d = dval;
      endcase
    end
  end

  always_comb begin
    at_f0       = (state_q == S_RUN) && (fcnt_q == '0);
    accept      = in_valid && in_ready_q;
    idx_d       = idx_q;
    bank_full_d = bank_full_q;
    in_ready_d  = in_ready_q;
    sel_d       = sel_q;
    shown_d     = shown_q;
    mode_d      = mode_q;
    gain_d      = gain_q;
    ferr_d      = 1'b0;
    we0         = 1'b0;
    we1         = 1'b0;
    if (accept) begin
      we0 = sel_q;
      we1 = !sel_q;
      if (idx_q == A_LAST) begin
        bank_full_d = 1'b1;
        idx_d       = '0;
        in_ready_d  = 1'b0;
        ferr_d      = !in_last;
      end else if (in_last) begin
        ferr_d = 1'b1;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + AW'(1);
      end
    end
    // in_ready is low while bank_full_q is set, so no beat races the swap.
    if (at_f0) begin
      mode_d = mode_selector;
      gain_d = gain;
      if (bank_full_q) begin
        sel_d       = !sel_q;
        shown_d     = 1'b1;
        bank_full_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      icnt_q      <= '0;
      fcnt_q      <= '0;
      pat_q       <= '0;
      idx_q       <= '0;
      bank_full_q <= 1'b0;
      in_ready_q  <= 1'b1;
      sel_q       <= 1'b0;
      shown_q     <= 1'b0;
      mode_q      <= '0;
      gain_q      <= '0;
      flag_q      <= 1'b0;
      wt_en_q     <= 1'b0;
      wtaddr_q    <= '0;
      wtdina_q    <= '0;
      fstart_q    <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      icnt_q      <= icnt_d;
      fcnt_q      <= fcnt_d;
      pat_q       <= pat_d;
      idx_q       <= idx_d;
      bank_full_q <= bank_full_d;
      in_ready_q  <= in_ready_d;
      sel_q       <= sel_d;
      shown_q     <= shown_d;
      mode_q      <= mode_d;
      gain_q      <= gain_d;
      flag_q      <= flag_d;
      wt_en_q     <= wt_en_d;
      wtaddr_q    <= wtaddr_d;
      wtdina_q    <= wtdina_d;
      fstart_q    <= fstart_d;
      ferr_q      <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we0) mem0_q[idx_q] <= in_data;
    if (we1) mem1_q[idx_q] <= in_data;
  end

  assign in_ready      = in_ready_q;
  assign sdbpflag_wire = flag_q;
  assign wt_en         = wt_en_q;
  assign wtaddr_wire   = wtaddr_q;
  assign wtdina_wire   = wtdina_q;
  assign frame_start   = fstart_q;
  assign frame_err     = ferr_q;

endmodule

// File: tb/tb_led_frame_writer.sv
// Scoreboard bench for led_frame_writer: directed frames are queued as
// expected write beats; a monitor pops and compares each driver-RAM write.
module tb_led_frame_writer;

  localparam int N = 360;

  localparam int K_UNI    = 0;
  localparam int K_ZERO   = 1;
  localparam int K_DATA   = 2;
  localparam int K_BANDS  = 3;
  localparam int K_STRIPE = 4;

  localparam int I_RAMP = 0;
  localparam int I_A    = 1;
  localparam int I_B    = 2;
  localparam int I_C    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode_selector;
  logic [7:0]  gain;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        sdbpflag_wire;
  logic        wt_en;
  logic [9:0]  wtaddr_wire;
  logic [15:0] wtdina_wire;
  logic        frame_start;
  logic        frame_err;

  always #5 clk = ~clk;

  led_frame_writer #(
    .FRAME_CYCLES(1000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode_selector(mode_selector),
    .gain         (gain),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .sdbpflag_wire(sdbpflag_wire),
    .wt_en        (wt_en),
    .wtaddr_wire  (wtaddr_wire),
    .wtdina_wire  (wtdina_wire),
    .frame_start  (frame_start),
    .frame_err    (frame_err)
  );

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          ferr_cnt = 0;
  int          flag_cnt = 0;
  int          en_cnt = 0;
  bit          have_prev = 0;
  logic [15:0] seen [N];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, want %h at %0t", name, act, req, $time);
  endtask

  function automatic logic [7:0] pix(input int img, input int a);
    int v;
    case (img)
      I_RAMP:  v = a % 256;
      I_A:     v = 255 - (a % 256);
      I_B:     v = (a + 7) % 256;
      default: v = (a * 5) % 256;
    endcase
    return v[7:0];
  endfunction

  function automatic logic [15:0] expv(input int kind, input int img,
                                      input logic [7:0] g, input int a);
    int p;
    int r;
    p = int'(pix(img, a)) * int'(g);
    r = a % 24;
    case (kind)
      K_UNI:   return {g, 8'h00};
      K_ZERO:  return 16'h0000;
      K_DATA:  return p[15:0];
      K_BANDS: return (r < 8) ? 16'hFFFF : (r < 16) ? 16'h0100 : 16'h0000;
      default: return (r < 12) ? 16'hFFFF : p[15:0];
    endcase
  endfunction

  task automatic push_frame(input int kind, input int img, input logic [7:0] g);
    exp_t e;
    for (int a = 0; a < N; a++) begin
      e.addr = 10'(a);
      e.data = expv(kind, img, g, a);
      sbq.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      have_prev = 0;
      flag_cnt  = 0;
      en_cnt    = 0;
    end else begin
      if (frame_err) ferr_cnt++;
      if (frame_start) begin
        if (have_prev) begin
          chk("flag_len", flag_cnt, 30);
          chk("burst_len", en_cnt, 360);
        end
        have_prev = 1;
        flag_cnt  = 0;
        en_cnt    = 0;
      end
      if (sdbpflag_wire) flag_cnt++;
      if (wt_en) begin
        exp_t e;
        en_cnt++;
        if (wtaddr_wire < 10'(N)) seen[wtaddr_wire[8:0]] = wtdina_wire;
        if (sbq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_beat: addr %0d data %h, want none",
                   wtaddr_wire, wtdina_wire);
        end else begin
          e = sbq.pop_front();
          chk("wtaddr", 32'(wtaddr_wire), 32'(e.addr));
          chk("wtdina", 32'(wtdina_wire), 32'(e.data));
        end
      end else begin
        chk("idle_addr", 32'(wtaddr_wire), 0);
        chk("idle_data", 32'(wtdina_wire), 0);
      end
    end
  end

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 1100);
    if (!frame_start) begin
      n_chk++;
      $display("FAIL frame_timeout: no frame_start in %0d cycles, want <=1000", n);
    end
  endtask

  task automatic init_phase(input string name);
    int n = 0;
    int bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (sdbpflag_wire || wt_en || frame_err) bad++;
    end while (!frame_start && n < 3000);
    chk({name, "_len"}, n, 2500);
    chk({name, "_quiet"}, bad, 0);
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int w = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL ready_timeout: in_ready 0, want 1");
    end
    @(posedge clk);
  endtask

  task automatic load(input int img, input int cnt, input int last_at);
    for (int a = 0; a < cnt; a++) send(pix(img, a), a == last_at);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int e0;
    mode_selector = 2'b00;
    gain          = 8'hE0;
    in_valid      = 1'b0;
    in_data       = '0;
    in_last       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_flag", 32'(sdbpflag_wire), 0);
    chk("rst_wten", 32'(wt_en), 0);
    chk("rst_addr", 32'(wtaddr_wire), 0);
    chk("rst_data", 32'(wtdina_wire), 0);
    chk("rst_fstart", 32'(frame_start), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_ready", 32'(in_ready), 1);
    rst_n = 1'b1;

    init_phase("init");
    push_frame(K_UNI, 0, 8'hE0);
    repeat (10) @(negedge clk);
    mode_selector = 2'b11;
    gain          = 8'hFF;

    wait_frame();
    push_frame(K_ZERO, 0, 8'hFF);
    repeat (5) @(negedge clk);
    load(I_RAMP, N, N - 1);

    wait_frame();
    push_frame(K_DATA, I_RAMP, 8'hFF);
    fork
      begin
        load(I_A, N, N - 1);
        load(I_B, N, N - 1);
      end
      begin
        repeat (370) @(negedge clk);
        chk("ramp_a2", 32'(seen[2]), 32'h01FE);
        chk("ramp_a359", 32'(seen[359]), 32'h6699);
        wait_frame();
        chk("bp_ready_f0", 32'(in_ready), 0);
        push_frame(K_DATA, I_A, 8'hFF);
        @(negedge clk);
        chk("bp_ready_rise", 32'(in_ready), 1);
      end
    join

    wait_frame();
    push_frame(K_DATA, I_B, 8'hFF);
    repeat (5) @(negedge clk);
    e0 = ferr_cnt;
    load(I_C, 100, 99);
    repeat (5) @(negedge clk);
    chk("err_short", ferr_cnt - e0, 1);

    wait_frame();
    push_frame(K_DATA, I_B, 8'hFF);
    repeat (5) @(negedge clk);
    e0 = ferr_cnt;
    load(I_C, N, -1);
    repeat (5) @(negedge clk);
    chk("err_nolast", ferr_cnt - e0, 1);

    wait_frame();
    push_frame(K_DATA, I_C, 8'hFF);
    repeat (200) @(negedge clk);
    mode_selector = 2'b10;

    wait_frame();
    push_frame(K_BANDS, 0, 8'hFF);
    repeat (370) @(negedge clk);
    chk("band_a0", 32'(seen[0]), 32'hFFFF);
    chk("band_a8", 32'(seen[8]), 32'h0100);
    chk("band_a16", 32'(seen[16]), 32'h0000);
    chk("band_a24", 32'(seen[24]), 32'hFFFF);
    mode_selector = 2'b01;

    wait_frame();
    push_frame(K_STRIPE, I_C, 8'hFF);
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_flag", 32'(sdbpflag_wire), 0);
    chk("mid_wten", 32'(wt_en), 0);
    chk("mid_addr", 32'(wtaddr_wire), 0);
    chk("mid_data", 32'(wtdina_wire), 0);
    chk("mid_fstart", 32'(frame_start), 0);
    chk("mid_ready", 32'(in_ready), 1);
    sbq.delete();
    mode_selector = 2'b00;
    gain          = 8'h40;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    init_phase("reinit");
    push_frame(K_UNI, 0, 8'h40);
    wait_frame();
    chk("sb_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
